// File: rtl/nibble_sub_pkg.sv
// nibble_sub_pkg: shared widths, FSM state and slice-index types for the nibble-serial subtractor.
package nibble_sub_pkg;
  localparam int WIDTH = 16;
  localparam int NIB = 4;
  localparam int NSLICES = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef logic [$clog2(NSLICES)-1:0] idx_t;
endpackage

// File: rtl/nibble_sub_slice.sv
// nibble_sub_slice: combinational one-nibble subtract d = x - y - bin with borrow out.
module nibble_sub_slice
  import nibble_sub_pkg::*;
(
  input  logic [NIB-1:0] x,
  input  logic [NIB-1:0] y,
  input  logic           bin,
  output logic [NIB-1:0] d,
  output logic           bout
);
  logic [NIB:0] w_res;
  assign w_res = {1'b0, x} - {1'b0, y} - {{NIB{1'b0}}, bin};
  assign d = w_res[NIB-1:0];
  assign bout = w_res[NIB];
endmodule

// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: 16-bit a - b - borrow_in, one nibble per clock, LSB nibble first.
// Define NIBBLE_SUB_OVF_EN to enable the signed-overflow flag; otherwise ovf is tied low.
module nibble_serial_subtractor
  import nibble_sub_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);
  state_e           r_state, w_state_nxt;
  idx_t             r_idx;
  logic [WIDTH-1:0] r_a, r_b, r_diff, w_diff_nxt;
  logic             r_bor, r_borrow_out, r_zero, r_neg;
  logic [NIB-1:0]   w_d;
  logic             w_bout, w_accept, w_last;

  assign in_ready = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign w_accept = in_valid && in_ready;
  assign w_last = r_state == RUN && r_idx == idx_t'(NSLICES - 1);

  nibble_sub_slice u_slice (
    .x   (r_a[r_idx*NIB +: NIB]),
    .y   (r_b[r_idx*NIB +: NIB]),
    .bin (r_bor),
    .d   (w_d),
    .bout(w_bout)
  );

  always_comb begin
    w_diff_nxt = r_diff;
    w_diff_nxt[r_idx*NIB +: NIB] = w_d;
    w_state_nxt = w_accept ? RUN : w_last ? DONE : (out_valid && out_ready) ? IDLE : r_state;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_nxt;

  // Flags are captured from the completed result on the last slice and dropped on handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
      r_diff <= '0;
      r_idx <= '0;
      r_bor <= 1'b0;
      r_borrow_out <= 1'b0;
      r_zero <= 1'b0;
      r_neg <= 1'b0;
    end else if (w_accept) begin
      r_a <= a;
      r_b <= b;
      r_diff <= '0;
      r_idx <= '0;
      r_bor <= borrow_in;
    end else if (r_state == RUN) begin
      r_diff <= w_diff_nxt;
      r_bor <= w_bout;
      r_idx <= r_idx + 1'b1;
      if (w_last) begin
        r_borrow_out <= w_bout;
        r_zero <= w_diff_nxt == '0;
        r_neg <= w_diff_nxt[WIDTH-1];
      end
    end else if (out_valid && out_ready) begin
      r_borrow_out <= 1'b0;
      r_zero <= 1'b0;
      r_neg <= 1'b0;
    end
  end

`ifdef NIBBLE_SUB_OVF_EN
  logic r_ovf;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ovf <= 1'b0;
    else if (w_last) r_ovf <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff_nxt[WIDTH-1] != r_a[WIDTH-1]);
    else if (w_accept || (out_valid && out_ready)) r_ovf <= 1'b0;
  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign diff = r_diff;
  assign borrow_out = r_borrow_out;
  assign zero = r_zero;
  assign neg = r_neg;
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb_nibble_serial_subtractor: directed checks of the nibble-serial subtractor.
module tb_nibble_serial_subtractor;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        borrow_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] diff;
  logic        borrow_out, zero, neg, ovf;
  int          n_pass = 0;
  int          n_chk = 0;

`ifdef NIBBLE_SUB_OVF_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  nibble_serial_subtractor dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .borrow_in(borrow_in), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow_out(borrow_out), .zero(zero), .neg(neg), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic ibin, output int lat);
    a = ia;
    b = ib;
    borrow_in = ibin;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~ia;
    b = ~ib;
    borrow_in = ~ibin;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_chk++;
    if ({out_valid, diff, borrow_out, zero, neg, ovf} !== 21'd0)
      $display("FAIL reset_outputs: got ov=%b diff=%h bo=%b z=%b n=%b o=%b want all 0", out_valid, diff, borrow_out, zero, neg, ovf);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if ({in_ready, out_valid} !== 2'b10) $display("FAIL reset_ready: got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
    else n_pass++;
  endtask

  typedef struct {
    logic [15:0] va, vb;
    logic        vbin;
    logic [15:0] vd;
    logic [3:0]  vf;
  } vec_t;

  task automatic test_arith();
    vec_t v[6];
    int lat;
    v[0] = '{16'h0F0F, 16'h000F, 1'b0, 16'h0F00, 4'b0000};
    v[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 4'b1010};
    v[2] = '{16'h1234, 16'h1234, 1'b0, 16'h0000, 4'b0100};
    v[3] = '{16'h0010, 16'h0000, 1'b1, 16'h000F, 4'b0000};
    v[4] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, {3'b000, EXP_OVF}};
    v[5] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 4'b1010};
    for (int i = 0; i < 6; i++) begin
      issue(v[i].va, v[i].vb, v[i].vbin, lat);
      n_chk++;
      if (lat !== 4) $display("FAIL arith_latency[%0d]: got %0d cycles want 4", i, lat);
      else n_pass++;
      n_chk++;
      if (diff !== v[i].vd) $display("FAIL arith_diff[%0d]: got %h want %h", i, diff, v[i].vd);
      else n_pass++;
      n_chk++;
      if ({borrow_out, zero, neg, ovf} !== v[i].vf)
        $display("FAIL arith_flags[%0d]: got bo/z/n/o=%b want %b", i, {borrow_out, zero, neg, ovf}, v[i].vf);
      else n_pass++;
      n_chk++;
      if (in_ready !== 1'b0) $display("FAIL arith_ready_in_done[%0d]: got %b want 0", i, in_ready);
      else n_pass++;
      drain();
      n_chk++;
      if ({in_ready, out_valid, zero, neg, ovf} !== 5'b10000)
        $display("FAIL arith_after_drain[%0d]: got ir/ov/z/n/o=%b want 10000", i, {in_ready, out_valid, zero, neg, ovf});
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    issue(16'h5555, 16'h1111, 1'b0, lat);
    n_chk++;
    if (lat !== 4 || diff !== 16'h4444) $display("FAIL bp_first: got lat=%0d diff=%h want lat=4 diff=4444", lat, diff);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = 16'hFFFF;
      b = 16'h0000;
      borrow_in = 1'b0;
      @(posedge clk); #1;
      n_chk++;
      if ({out_valid, in_ready, diff, borrow_out, zero, neg} !== {2'b10, 16'h4444, 3'b000})
        $display("FAIL bp_hold[%0d]: got ov=%b ir=%b diff=%h bo/z/n=%b%b%b want ov=1 ir=0 diff=4444 000", i, out_valid, in_ready, diff, borrow_out, zero, neg);
      else n_pass++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_chk++;
    if ({out_valid, in_ready} !== 2'b01) $display("FAIL bp_release: got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
    else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'h0000;
    n_chk++;
    if (in_ready !== 1'b0) $display("FAIL bp_second_accept: got ir=%b want 0", in_ready);
    else n_pass++;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_chk++;
    if (lat !== 4 || diff !== 16'hFFFF || borrow_out !== 1'b0 || neg !== 1'b1)
      $display("FAIL bp_second_result: got lat=%0d diff=%h bo=%b n=%b want lat=4 diff=ffff bo=0 n=1", lat, diff, borrow_out, neg);
    else n_pass++;
    drain();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    a = 16'hABCD;
    b = 16'h1234;
    borrow_in = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({out_valid, diff, borrow_out, zero, neg, ovf} !== 21'd0)
      $display("FAIL midrun_reset: got ov=%b diff=%h bo=%b z=%b n=%b o=%b want all 0", out_valid, diff, borrow_out, zero, neg, ovf);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if ({in_ready, out_valid} !== 2'b10) $display("FAIL midrun_ready: got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
    else n_pass++;
    issue(16'h0005, 16'h0003, 1'b0, lat);
    n_chk++;
    if (lat !== 4 || diff !== 16'h0002 || {borrow_out, zero, neg} !== 3'b000)
      $display("FAIL midrun_fresh: got lat=%0d diff=%h bo/z/n=%b%b%b want lat=4 diff=0002 000", lat, diff, borrow_out, zero, neg);
    else n_pass++;
    drain();
  endtask

  initial begin
    test_reset();
    test_arith();
    test_backpressure();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/nibble_serial_subtractor.md
# nibble_serial_subtractor

Multi-cycle 16-bit subtractor computing A − B − borrow_in one 4-bit slice per clock, least-significant nibble first, with the borrow rippled through a register between slices. It is the subtract-side counterpart to the team's nibble-sliced 16-bit adder and feeds the ALU result mux. Operands are taken and results are returned over valid/ready handshakes.

## Interface
- WIDTH, 16: operand/result width; fixed, must equal NIB × NSLICES.
- NIB, 4: slice width in bits.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  16  minuend.
- b  input  16  subtrahend.
- borrow_in  input  1  incoming borrow.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- diff  output  16  (a − b − borrow_in) mod 2^16.
- borrow_out  output  1  1 iff unsigned a < b + borrow_in.
- zero  output  1  diff == 0.
- neg  output  1  diff[15].
- ovf  output  1  signed overflow; see Configuration.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready = 1. On in_valid && in_ready, latch a, b, borrow_in, clear diff and idx, load borrow register with borrow_in, go to RUN.
- RUN: each cycle the slice computes a[idx] − b[idx] − borrow_reg over one nibble. It writes the 4-bit result into diff[idx] and the slice borrow into borrow_reg, then increments idx. After idx = 3, go to DONE.
- DONE: out_valid = 1. diff, borrow_out, zero, neg and ovf are stable and registered. On out_ready, go to IDLE.
- Operands are captured. Changes on a, b and borrow_in outside the accept cycle have no effect.
- in_valid during RUN or DONE is ignored because in_ready = 0. It is accepted no earlier than the cycle after DONE exits.
- Arithmetic is unsigned modulo 2^16. borrow_out is the borrow out of slice 3.
- zero, neg and ovf are computed from the final diff and are valid only while out_valid = 1. They are 0 otherwise.
- Reset, asynchronous at any time including mid-RUN: state = IDLE, in_ready = 1 after deassertion. out_valid, diff, borrow_out, zero, neg, ovf, idx and borrow_reg all = 0. A partial result is discarded.

## Timing
- Accept edge T0. RUN covers edges T1..T4. out_valid is high in the cycle after T4 (4 cycles of latency after accept).
- Result is held indefinitely while out_ready = 0.
- The DONE→IDLE edge occurs on the first edge with out_ready = 1. in_ready rises in the following cycle.
- Minimum issue interval is 6 cycles. There is no overlap of operations.
- out_valid and in_ready are never both 1.

## Configuration
- NIBBLE_SUB_OVF_EN defined: ovf = (a[15] ≠ b[15]) && (diff[15] ≠ a[15]), using the latched operands. It is registered with the other flags in DONE.
- Undefined: ovf is tied to 0. The port still exists and no overflow logic is synthesised.

## Structure
- Package nibble_sub_pkg holds:
  - WIDTH, NIB, NSLICES = 4.
  - The state enum {IDLE, RUN, DONE}.
  - The idx type (2 bits).
- Sub-module nibble_sub_slice is purely combinational:
  - Inputs: 4-bit x, 4-bit y, bin.
  - Outputs: 4-bit d and bout, where d = x − y − bin and bout = borrow.
  - It is instantiated once and time-multiplexed by idx.
- The top level holds the FSM, operand latches, borrow register and flag logic.

## Test plan
- a=0x0F0F, b=0x000F, bin=0 → diff=0x0F00, borrow_out=0, zero=0, neg=0; out_valid exactly 4 cycles after accept.
- a=0x0000, b=0x0001, bin=0 → diff=0xFFFF, borrow_out=1, neg=1, ovf=0.
- a=0x1234, b=0x1234, bin=0 → diff=0x0000, zero=1, borrow_out=0. Then a=0x0010, b=0x0000, bin=1 → diff=0x000F, which checks the borrow crossing a slice boundary.
- a=0x8000, b=0x0001, bin=0 → diff=0x7FFF, borrow_out=0, ovf=1 with NIBBLE_SUB_OVF_EN and ovf=0 without.
- Backpressure: hold out_ready=0 for 3 cycles in DONE → diff and flags stable, in_ready=0, a second in_valid is ignored. It is accepted only after the out_ready handshake plus one cycle.
- Assert rst_n=0 in the second RUN cycle → all outputs 0 immediately. After release, in_ready=1 and a fresh 0x0005 − 0x0003 yields 0x0002.
